mipi_rx_line_sequencer: RTL and testbench
=========================================

// Module: mipi_rx_line_sequencer
// PURPOSE
//  Sits between the CSI-2 packet decoder and the pixel depackers (RAW8/RAW10/RAW12, 4-lane, 32-bit words).
//  Tracks frame/line framing from short packets, validates long-packet headers, forwards exactly WC payload
//  bytes to the selected depacker, and enforces an idle gap between lines so depacker alignment state resets.
//  Produces frame/line valids, counters and one-cycle error strobes for the parallel-output stage.
// PARAMETERS
//  GAP_CYCLES  2        cycles depack_valid_o held low after each line (min 1; covers 1-cycle depacker latency)
//  MAX_WC      16'd8192 largest accepted long-packet word count (bytes); larger -> err_wc_o, line dropped
// PORTS
//  clk_i             in   1   byte/word clock
//  reset_n_i         in   1   asynchronous active-low reset
//  hdr_valid_i       in   1   packet header strobe from decoder (1 cycle)
//  hdr_dt_i          in   6   CSI-2 data type of header
//  hdr_wc_i          in   16  word count (long) / data field (short)
//  payload_valid_i   in   1   payload word valid
//  payload_i         in   32  4 payload bytes, byte0 in [7:0]
//  depack_valid_o    out  1   data-valid to selected depacker
//  depack_data_o     out  32  payload word to depacker
//  depack_sel_o      out  2   0=RAW8 1=RAW10 2=RAW12
//  pix_valid_i       in   1   depacker output-valid (4 pixels per assertion)
//  frame_valid_o     out  1   high FS..FE
//  line_valid_o      out  1   high while line in PAYLOAD or GAP
//  frame_count_o     out  16  frames started since reset (wraps)
//  line_count_o      out  16  lines completed in current frame (wraps)
//  line_pixels_o     out  16  pixels (4 x pix_valid_i) of last completed line, latched at GAP exit
//  err_seq_o         out  1   strobe: long packet outside frame, or FS inside frame
//  err_dt_o          out  1   strobe: unsupported long-packet data type
//  err_wc_o          out  1   strobe: WC==0, WC>MAX_WC, or WC not multiple of 4/20/12 (RAW8/10/12)
//  err_overrun_o     out  1   strobe: payload word outside PAYLOAD/DROP, or header during PAYLOAD/DROP
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; depack_sel_o=1.
//  States: IDLE, FRAME, PAYLOAD, DROP, GAP.
//  IDLE: FS(0x00) -> frame_valid_o=1, frame_count_o+1, line_count_o=0, FRAME. Long header -> err_seq_o, DROP
//   ceil(WC/4) words. FE/LS/LE/other short ignored.
//  FRAME: FE(0x01) -> frame_valid_o=0, IDLE. FS -> err_seq_o, restart frame (frame_count_o+1, line_count_o=0).
//   Long DT 0x2A/0x2B/0x2C with legal WC -> load words_left=WC>>2, depack_sel_o, PAYLOAD.
//   Long DT illegal -> err_dt_o; illegal WC -> err_wc_o (DT check wins); both -> DROP (WC=0 stays FRAME).
//   DT 0x02-0x0F short ignored; DT>=0x10 is long.
//  PAYLOAD: each payload_valid_i -> depack_data_o<=payload_i, depack_valid_o=1 next cycle (1-cycle latency);
//   words_left-1; at 0 -> GAP. Cycles without payload_valid_i: depack_valid_o=0 (pause; no alignment reset).
//  DROP: consume words_left words, nothing forwarded; then FRAME (or IDLE if not in frame).
//  GAP: depack_valid_o=0 for GAP_CYCLES cycles; pix_valid_i still counted; on exit line_count_o+1,
//   line_pixels_o latched, pixel counter cleared, -> FRAME.
//  Pixel counter: +4 per pix_valid_i in PAYLOAD/GAP, saturates at 16'hFFFC.
//  Simultaneous hdr_valid_i & payload_valid_i: header processed, payload word dropped, err_overrun_o.
//  Header during PAYLOAD/DROP: err_overrun_o, line aborted (no line_count_o increment), header then
//   processed as in FRAME next cycle via GAP skip; FE in this case closes frame directly.
//  Counters wrap at 16 bits. Errors are single-cycle strobes, never sticky.
//  Reset mid-line: immediate async clear; depack_valid_o low, depacker resynchronises on next line.
// TESTING
//  FS, RAW10 WC=40 (10 words back-to-back), FE -> 10 depack_valid_o pulses, 1-cycle latency, sel=1,
//   line_count_o=1, frame_count_o=1, frame_valid_o low after FE.
//  RAW10 WC=42 in frame -> err_wc_o 1 cycle, 11 words dropped, depack_valid_o stays 0, line_count_o unchanged.
//  Long header DT=0x30 WC=8 -> err_dt_o, 2 words dropped; header before FS -> err_seq_o.
//  FS, RAW8 WC=16, second header after 2 words -> err_overrun_o, line_count_o=0, new header accepted.
//  Payload with 3-cycle stall mid-line -> depack_valid_o gaps match, total pulses = WC/4, no GAP inserted.
//  Reset asserted mid-PAYLOAD -> all outputs 0 same cycle; next FS/line behaves as clean start.

Source files
------------

// File: rtl/mipi_rx_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_rx_line_sequencer
//  Description : CSI-2 frame/line framing tracker between the packet decoder
//                and the RAW8/RAW10/RAW12 depackers. It validates long-packet
//                headers, forwards exactly WC payload bytes, and inserts an
//                idle gap after each line. It also provides counters and
//                single-cycle error strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module mipi_rx_line_sequencer #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [15:0] MAX_WC     = 16'd8192
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        hdr_valid_i,
  input  logic [5:0]  hdr_dt_i,
  input  logic [15:0] hdr_wc_i,
  input  logic        payload_valid_i,
  input  logic [31:0] payload_i,
  output logic        depack_valid_o,
  output logic [31:0] depack_data_o,
  output logic [1:0]  depack_sel_o,
  input  logic        pix_valid_i,
  output logic        frame_valid_o,
  output logic        line_valid_o,
  output logic [15:0] frame_count_o,
  output logic [15:0] line_count_o,
  output logic [15:0] line_pixels_o,
  output logic        err_seq_o,
  output logic        err_dt_o,
  output logic        err_wc_o,
  output logic        err_overrun_o
);

  typedef enum logic [2:0] {IDLE, FRAME, PAYLOAD, DROP, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [15:0]   words_left, words_left_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [15:0]   pix_cnt, pix_cnt_nxt;
  // A header that interrupts a line is parked here and handled one cycle later
  logic          pend, pend_nxt;
  logic [5:0]    pend_dt, pend_dt_nxt;
  logic [15:0]   pend_wc, pend_wc_nxt;

  logic          depack_valid_nxt, frame_valid_nxt, line_valid_nxt;
  logic [31:0]   depack_data_nxt;
  logic [1:0]    depack_sel_nxt;
  logic [15:0]   frame_count_nxt, line_count_nxt, line_pixels_nxt;
  logic          err_seq_nxt, err_dt_nxt, err_wc_nxt, err_overrun_nxt;

  logic          hdr_go;
  logic [5:0]    dt;
  logic [15:0]   wc;
  logic          is_long, dt_ok, wc_mult, wc_ok;
  logic [15:0]   words_ceil, pix_inc;
  logic [1:0]    sel_dec;

  // Header decode: a parked header takes priority over the live one
  assign dt         = pend ? pend_dt : hdr_dt_i;
  assign wc         = pend ? pend_wc : hdr_wc_i;
  assign is_long    = (dt >= 6'h10);
  assign dt_ok      = (dt == 6'h2A) || (dt == 6'h2B) || (dt == 6'h2C);
  assign wc_mult    = (dt == 6'h2A) ? (wc[1:0] == 2'b00) :
                      (dt == 6'h2B) ? ((wc % 16'd20) == 16'd0) :
                                      ((wc % 16'd12) == 16'd0);
  assign wc_ok      = (wc != 16'd0) && (wc <= MAX_WC) && wc_mult;
  assign words_ceil = 16'((17'(wc) + 17'd3) >> 2);
  assign sel_dec    = (dt == 6'h2A) ? 2'd0 : (dt == 6'h2B) ? 2'd1 : 2'd2;
  assign pix_inc    = (pix_cnt >= 16'hFFFC) ? 16'hFFFC : pix_cnt + 16'd4;

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state;
    words_left_nxt   = words_left;
    gap_cnt_nxt      = gap_cnt;
    pix_cnt_nxt      = pix_cnt;
    pend_nxt         = 1'b0;
    pend_dt_nxt      = pend_dt;
    pend_wc_nxt      = pend_wc;
    depack_valid_nxt = 1'b0;
    depack_data_nxt  = depack_data_o;
    depack_sel_nxt   = depack_sel_o;
    frame_valid_nxt  = frame_valid_o;
    frame_count_nxt  = frame_count_o;
    line_count_nxt   = line_count_o;
    line_pixels_nxt  = line_pixels_o;
    err_seq_nxt      = 1'b0;
    err_dt_nxt       = 1'b0;
    err_wc_nxt       = 1'b0;
    err_overrun_nxt  = 1'b0;
    hdr_go           = 1'b0;

    if (pix_valid_i && (state == PAYLOAD || state == GAP)) pix_cnt_nxt = pix_inc;

    case (state)
      IDLE, FRAME: begin
        hdr_go = pend | hdr_valid_i;
        if ((pend && hdr_valid_i) || payload_valid_i) err_overrun_nxt = 1'b1;
      end
      PAYLOAD, DROP: begin
        if (hdr_valid_i) begin
          // Line aborted: no line count, pixels discarded, header deferred
          err_overrun_nxt = 1'b1;
          pend_nxt        = 1'b1;
          pend_dt_nxt     = hdr_dt_i;
          pend_wc_nxt     = hdr_wc_i;
          pix_cnt_nxt     = 16'd0;
          state_nxt       = frame_valid_o ? FRAME : IDLE;
        end else if (payload_valid_i) begin
          if (state == PAYLOAD) begin
            depack_valid_nxt = 1'b1;
            depack_data_nxt  = payload_i;
          end
          words_left_nxt = words_left - 16'd1;
          if (words_left == 16'd1) begin
            if (state == PAYLOAD) begin
              state_nxt   = GAP;
              gap_cnt_nxt = '0;
            end else begin
              state_nxt = frame_valid_o ? FRAME : IDLE;
            end
          end
        end
      end
      GAP: begin
        if (payload_valid_i) err_overrun_nxt = 1'b1;
        // A header here ends the gap early; the line still counts as complete
        if (hdr_valid_i || gap_cnt == GAP_LAST) begin
          line_count_nxt  = line_count_o + 16'd1;
          line_pixels_nxt = pix_cnt_nxt;
          pix_cnt_nxt     = 16'd0;
          state_nxt       = FRAME;
          hdr_go          = hdr_valid_i;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (hdr_go) begin
      if (!is_long) begin
        if (dt == 6'h00) begin
          err_seq_nxt     = frame_valid_o;
          frame_valid_nxt = 1'b1;
          frame_count_nxt = frame_count_o + 16'd1;
          line_count_nxt  = 16'd0;
          state_nxt       = FRAME;
        end else if (dt == 6'h01 && frame_valid_o) begin
          frame_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end
      end else if (!frame_valid_o) begin
        err_seq_nxt    = 1'b1;
        words_left_nxt = words_ceil;
        state_nxt      = (words_ceil == 16'd0) ? IDLE : DROP;
      end else if (dt_ok && wc_ok) begin
        words_left_nxt = wc >> 2;
        depack_sel_nxt = sel_dec;
        state_nxt      = PAYLOAD;
      end else begin
        err_dt_nxt     = !dt_ok;
        err_wc_nxt     = dt_ok;
        words_left_nxt = words_ceil;
        state_nxt      = (words_ceil == 16'd0) ? FRAME : DROP;
      end
    end

    line_valid_nxt = (state_nxt == PAYLOAD) || (state_nxt == GAP);
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      words_left     <= 16'd0;
      gap_cnt        <= '0;
      pix_cnt        <= 16'd0;
      pend           <= 1'b0;
      pend_dt        <= 6'd0;
      pend_wc        <= 16'd0;
      depack_valid_o <= 1'b0;
      depack_data_o  <= 32'd0;
      depack_sel_o   <= 2'd1;
      frame_valid_o  <= 1'b0;
      line_valid_o   <= 1'b0;
      frame_count_o  <= 16'd0;
      line_count_o   <= 16'd0;
      line_pixels_o  <= 16'd0;
      err_seq_o      <= 1'b0;
      err_dt_o       <= 1'b0;
      err_wc_o       <= 1'b0;
      err_overrun_o  <= 1'b0;
    end else begin
      state          <= state_nxt;
      words_left     <= words_left_nxt;
      gap_cnt        <= gap_cnt_nxt;
      pix_cnt        <= pix_cnt_nxt;
      pend           <= pend_nxt;
      pend_dt        <= pend_dt_nxt;
      pend_wc        <= pend_wc_nxt;
      depack_valid_o <= depack_valid_nxt;
      depack_data_o  <= depack_data_nxt;
      depack_sel_o   <= depack_sel_nxt;
      frame_valid_o  <= frame_valid_nxt;
      line_valid_o   <= line_valid_nxt;
      frame_count_o  <= frame_count_nxt;
      line_count_o   <= line_count_nxt;
      line_pixels_o  <= line_pixels_nxt;
      err_seq_o      <= err_seq_nxt;
      err_dt_o       <= err_dt_nxt;
      err_wc_o       <= err_wc_nxt;
      err_overrun_o  <= err_overrun_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mipi_rx_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mipi_rx_line_sequencer
//  Description : Directed self-checking bench for mipi_rx_line_sequencer
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mipi_rx_line_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hdr_valid;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        payload_valid;
  logic [31:0] payload;
  logic        depack_valid;
  logic [31:0] depack_data;
  logic [1:0]  depack_sel;
  logic        pix_valid;
  logic        frame_valid, line_valid;
  logic [15:0] frame_count, line_count, line_pixels;
  logic        err_seq, err_dt, err_wc, err_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mipi_rx_line_sequencer dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .hdr_valid_i     (hdr_valid),
    .hdr_dt_i        (hdr_dt),
    .hdr_wc_i        (hdr_wc),
    .payload_valid_i (payload_valid),
    .payload_i       (payload),
    .depack_valid_o  (depack_valid),
    .depack_data_o   (depack_data),
    .depack_sel_o    (depack_sel),
    .pix_valid_i     (pix_valid),
    .frame_valid_o   (frame_valid),
    .line_valid_o    (line_valid),
    .frame_count_o   (frame_count),
    .line_count_o    (line_count),
    .line_pixels_o   (line_pixels),
    .err_seq_o       (err_seq),
    .err_dt_o        (err_dt),
    .err_wc_o        (err_wc),
    .err_overrun_o   (err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [5:0] dt, input logic [15:0] wc);
    hdr_valid = 1'b1;
    hdr_dt    = dt;
    hdr_wc    = wc;
    step();
    hdr_valid = 1'b0;
  endtask

  task automatic word(input logic [31:0] d);
    payload_valid = 1'b1;
    payload       = d;
    step();
    payload_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; hdr_valid = 1'b0; hdr_dt = 6'd0; hdr_wc = 16'd0;
    payload_valid = 1'b0; payload = 32'd0; pix_valid = 1'b0;
    step(); step();
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_depack_valid", depack_valid, 1'b0);
    chk("rst_depack_sel", depack_sel, 2'd1);
    chk("rst_counts", {frame_count, line_count}, 32'd0);
    chk("rst_line_pixels", line_pixels, 16'd0);
    chk("rst_errs", {err_seq, err_dt, err_wc, err_overrun}, 4'b0);
    reset_n = 1'b1;
    step();

    // Clean RAW10 line of 10 words, 5 pixel strobes
    hdr(6'h00, 16'd0);
    chk("fs_frame_valid", frame_valid, 1'b1);
    chk("fs_frame_count", frame_count, 16'd1);
    chk("fs_err_seq", err_seq, 1'b0);
    hdr(6'h2B, 16'd40);
    chk("raw10_line_valid", line_valid, 1'b1);
    chk("raw10_sel", depack_sel, 2'd1);
    chk("raw10_hdr_no_data", depack_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      payload_valid = 1'b1;
      payload       = 32'hA000_0000 + i;
      pix_valid     = (i % 2 == 0);
      step();
      chk("raw10_dv", depack_valid, 1'b1);
      chk("raw10_data", depack_data, 32'hA000_0000 + i);
    end
    payload_valid = 1'b0; pix_valid = 1'b0;
    step();
    chk("gap1_dv", depack_valid, 1'b0);
    chk("gap1_line_valid", line_valid, 1'b1);
    chk("gap1_line_count", line_count, 16'd0);
    step();
    chk("gap_exit_line_count", line_count, 16'd1);
    chk("gap_exit_pixels", line_pixels, 16'd20);
    chk("gap_exit_line_valid", line_valid, 1'b0);
    hdr(6'h01, 16'd0);
    chk("fe_frame_valid", frame_valid, 1'b0);
    chk("fe_frame_count", frame_count, 16'd1);
    chk("fe_line_count", line_count, 16'd1);

    // Illegal RAW10 WC, then WC=0, then a one-word RAW8 line
    hdr(6'h00, 16'd0);
    chk("fs2_frame_count", frame_count, 16'd2);
    chk("fs2_line_count", line_count, 16'd0);
    hdr(6'h2B, 16'd42);
    chk("wc42_err_wc", err_wc, 1'b1);
    chk("wc42_err_dt", err_dt, 1'b0);
    chk("wc42_line_valid", line_valid, 1'b0);
    for (int i = 0; i < 11; i++) begin
      word(32'hDEAD_0000 + i);
      chk("drop_dv", depack_valid, 1'b0);
      chk("drop_overrun", err_overrun, 1'b0);
      if (i == 0) chk("wc42_strobe_clear", err_wc, 1'b0);
    end
    chk("drop_line_count", line_count, 16'd0);
    hdr(6'h2A, 16'd0);
    chk("wc0_err_wc", err_wc, 1'b1);
    chk("wc0_line_valid", line_valid, 1'b0);
    hdr(6'h2A, 16'd4);
    chk("raw8_err_wc", err_wc, 1'b0);
    chk("raw8_line_valid", line_valid, 1'b1);
    chk("raw8_sel", depack_sel, 2'd0);
    word(32'h1234_5678);
    chk("raw8_dv", depack_valid, 1'b1);
    chk("raw8_overrun", err_overrun, 1'b0);
    step(); step();
    chk("raw8_line_count", line_count, 16'd1);

    // Unsupported DT drops two words; a third word is an overrun
    hdr(6'h30, 16'd8);
    chk("dt30_err_dt", err_dt, 1'b1);
    chk("dt30_err_wc", err_wc, 1'b0);
    word(32'h1); chk("dt30_drop_dv", depack_valid, 1'b0);
    word(32'h2); chk("dt30_drop_overrun", err_overrun, 1'b0);
    word(32'h3); chk("dt30_extra_overrun", err_overrun, 1'b1);
    hdr(6'h01, 16'd0);
    chk("fe2_frame_valid", frame_valid, 1'b0);

    // Long header outside a frame
    hdr(6'h2A, 16'd8);
    chk("oof_err_seq", err_seq, 1'b1);
    chk("oof_frame_valid", frame_valid, 1'b0);
    word(32'h4); word(32'h5);
    chk("oof_drop_overrun", err_overrun, 1'b0);
    word(32'h6);
    chk("oof_extra_overrun", err_overrun, 1'b1);

    // Header interrupting a RAW8 line
    hdr(6'h00, 16'd0);
    chk("fs3_frame_count", frame_count, 16'd3);
    hdr(6'h2A, 16'd16);
    word(32'h10); chk("abort_w0", depack_valid, 1'b1);
    word(32'h11); chk("abort_w1", depack_valid, 1'b1);
    hdr(6'h2A, 16'd8);
    chk("abort_overrun", err_overrun, 1'b1);
    chk("abort_line_valid", line_valid, 1'b0);
    step();
    chk("abort_new_line_valid", line_valid, 1'b1);
    chk("abort_overrun_clear", err_overrun, 1'b0);
    chk("abort_line_count", line_count, 16'd0);
    word(32'h20); chk("abort_n0", depack_valid, 1'b1);
    word(32'h21); chk("abort_n1", depack_valid, 1'b1);
    step(); step();
    chk("abort_after_line_count", line_count, 16'd1);

    // RAW12 line with 3-cycle stall
    hdr(6'h2C, 16'd24);
    chk("raw12_sel", depack_sel, 2'd2);
    word(32'h30); chk("stall_w0", depack_valid, 1'b1);
    word(32'h31); chk("stall_w1", depack_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_dv_low", depack_valid, 1'b0);
      chk("stall_line_valid", line_valid, 1'b1);
    end
    for (int i = 2; i < 6; i++) begin
      word(32'h30 + i);
      chk("stall_dv", depack_valid, 1'b1);
      chk("stall_data", depack_data, 32'h30 + i);
    end
    step(); step();
    chk("stall_line_count", line_count, 16'd2);

    // Word count boundaries around MAX_WC
    hdr(6'h2A, 16'd8196);
    chk("max_plus_err_wc", err_wc, 1'b1);
    payload_valid = 1'b1;
    repeat (2049) step();
    payload_valid = 1'b0;
    chk("max_plus_line_count", line_count, 16'd2);
    hdr(6'h2A, 16'd8192);
    chk("max_err_wc", err_wc, 1'b0);
    chk("max_line_valid", line_valid, 1'b1);
    payload_valid = 1'b1;
    repeat (2048) step();
    payload_valid = 1'b0;
    step(); step();
    chk("max_line_count", line_count, 16'd3);
    hdr(6'h01, 16'd0);
    chk("fe4_frame_valid", frame_valid, 1'b0);
    chk("fe4_overrun", err_overrun, 1'b0);

    // Asynchronous reset in the middle of a line
    hdr(6'h00, 16'd0);
    hdr(6'h2A, 16'd16);
    word(32'h40);
    word(32'h41);
    chk("pre_rst_dv", depack_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dv", depack_valid, 1'b0);
    chk("arst_valids", {frame_valid, line_valid}, 2'b00);
    chk("arst_counts", {frame_count, line_count}, 32'd0);
    chk("arst_sel", depack_sel, 2'd1);
    step();
    reset_n = 1'b1;
    step();
    hdr(6'h00, 16'd0);
    chk("post_rst_frame_count", frame_count, 16'd1);
    hdr(6'h2A, 16'd4);
    chk("post_rst_line_valid", line_valid, 1'b1);
    word(32'h50);
    chk("post_rst_dv", depack_valid, 1'b1);
    step(); step();
    chk("post_rst_line_count", line_count, 16'd1);
    chk("post_rst_pixels", line_pixels, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
